// File: rtl/z80_idx_bitop_rmw.sv
// z80_idx_bitop_rmw
// Read-modify-write engine for the indexed CB-prefix bit operations
// (SET, RES, BIT and the eight rotate/shift ops) on (IX/IY + d).
// One operation is accepted in IDLE, the operand is read from the
// effective address, modified, and written back (BIT skips the write).
// Z80 flags are produced alongside the result.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   op_valid_i/op_ready_o  operation handshake (ready only in IDLE)
//   op_kind_i           00 rot/shift, 01 BIT, 10 RES, 11 SET
//   op_bit_i            bit index for BIT/RES/SET
//   op_shift_i          RLC,RRC,RL,RR,SLA,SRA,SLL,SRL
//   base_i, disp_i      index register value and signed displacement
//   flags_in_i          current F register
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  bus request side
//   mem_rdata_i/mem_ack_i                      bus response side
//   done_o              one-cycle completion pulse
//   result_o            modified value (BIT: the value read)
//   flags_out_o         new F value
module z80_idx_bitop_rmw #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1,
  localparam int BW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [1:0]            op_kind_i,
  input  logic [BW-1:0]         op_bit_i,
  input  logic [2:0]            op_shift_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [7:0]            disp_i,
  input  logic [7:0]            flags_in_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [7:0]            flags_out_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [1:0] KIND_ROT = 2'b00;
  localparam logic [1:0] KIND_BIT = 2'b01;
  localparam logic [1:0] KIND_RES = 2'b10;
  localparam logic [1:0] KIND_SET = 2'b11;

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [BW-1:0]  MSB_IDX   = BW'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [1:0]              kind_q, kind_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [2:0]              shift_q, shift_d;
  logic [7:0]              flags_in_q, flags_in_d;
  logic [ADDR_WIDTH-1:0]   ea_q, ea_d;
  logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [7:0]              flags_q, flags_d;

  logic [DATA_WIDTH-1:0]   mask;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic                    shift_c;
  logic                    bit_val;
  logic                    ea_f5;
  logic                    ea_f3;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [7:0]              alu_flags;

  // BIT copies F5/F3 from the high byte of the effective address; narrower
  // address buses have no such bits and report zero.
  if (ADDR_WIDTH >= 14) begin : g_ea_hi
    assign ea_f5 = ea_q[13];
    assign ea_f3 = ea_q[11];
  end else begin : g_ea_lo
    assign ea_f5 = 1'b0;
    assign ea_f3 = 1'b0;
  end

  // Operand modification, evaluated on the raw bus data so the result and
  // flags can be registered on the same edge the read is acknowledged.
  always_comb begin
    mask       = DATA_WIDTH'(1) << bit_q;
    bit_val    = mem_rdata_i[bit_q];
    shift_r    = mem_rdata_i;
    shift_c    = 1'b0;
    alu_result = mem_rdata_i;
    alu_flags  = flags_in_q;

    case (shift_q)
      3'b000: begin
        shift_r = {mem_rdata_i[DATA_WIDTH-2:0], mem_rdata_i[DATA_WIDTH-1]};
        shift_c = mem_rdata_i[DATA_WIDTH-1];
      end
      3'b001: begin
        shift_r = {mem_rdata_i[0], mem_rdata_i[DATA_WIDTH-1:1]};
        shift_c = mem_rdata_i[0];
      end
      3'b010: begin
        shift_r = {mem_rdata_i[DATA_WIDTH-2:0], flags_in_q[0]};
        shift_c = mem_rdata_i[DATA_WIDTH-1];
      end
      3'b011: begin
        shift_r = {flags_in_q[0], mem_rdata_i[DATA_WIDTH-1:1]};
        shift_c = mem_rdata_i[0];
      end
      3'b100: begin
        shift_r = {mem_rdata_i[DATA_WIDTH-2:0], 1'b0};
        shift_c = mem_rdata_i[DATA_WIDTH-1];
      end
      3'b101: begin
        shift_r = {mem_rdata_i[DATA_WIDTH-1], mem_rdata_i[DATA_WIDTH-1:1]};
        shift_c = mem_rdata_i[0];
      end
      3'b110: begin
        shift_r = {mem_rdata_i[DATA_WIDTH-2:0], 1'b1};
        shift_c = mem_rdata_i[DATA_WIDTH-1];
      end
      default: begin
        shift_r = {1'b0, mem_rdata_i[DATA_WIDTH-1:1]};
        shift_c = mem_rdata_i[0];
      end
    endcase

    // Flag byte layout: S Z F5 H F3 P/V N C
    case (op_kind_sel(kind_q))
      KIND_ROT: begin
        alu_result = shift_r;
        alu_flags  = {shift_r[DATA_WIDTH-1], (shift_r == '0), shift_r[5], 1'b0,
                      shift_r[3], ~^shift_r, 1'b0, shift_c};
      end
      KIND_BIT: begin
        alu_result = mem_rdata_i;
        alu_flags  = {(bit_q == MSB_IDX) & bit_val, ~bit_val, ea_f5, 1'b1,
                      ea_f3, ~bit_val, 1'b0, flags_in_q[0]};
      end
      KIND_RES: begin
        alu_result = mem_rdata_i & ~mask;
        alu_flags  = flags_in_q;
      end
      default: begin
        alu_result = mem_rdata_i | mask;
        alu_flags  = flags_in_q;
      end
    endcase
  end

  function automatic logic [1:0] op_kind_sel(input logic [1:0] k);
    return k;
  endfunction

  // Next-state and register updates. Operation fields are captured only on
  // acceptance so later op_valid activity cannot disturb a running operation.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    flags_in_d = flags_in_q;
    ea_d       = ea_q;
    wait_cnt_d = wait_cnt_q;
    result_d   = result_q;
    flags_d    = flags_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid_i) begin
          kind_d     = op_kind_i;
          bit_d      = op_bit_i;
          shift_d    = op_shift_i;
          flags_in_d = flags_in_i;
          ea_d       = base_i + ADDR_WIDTH'($signed(disp_i));
          state_d    = S_RD;
        end
      end
      S_RD: begin
        if (mem_ack_i) begin
          result_d   = alu_result;
          flags_d    = alu_flags;
          wait_cnt_d = '0;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else if (kind_q == KIND_BIT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = (kind_q == KIND_BIT) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        if (mem_ack_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      kind_q     <= KIND_ROT;
      bit_q      <= '0;
      shift_q    <= '0;
      flags_in_q <= '0;
      ea_q       <= '0;
      wait_cnt_q <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      flags_in_q <= flags_in_d;
      ea_q       <= ea_d;
      wait_cnt_q <= wait_cnt_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  // Bus outputs come straight from registers, so they hold steady for the
  // whole of a stalled bus phase.
  assign op_ready_o  = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we_o    = (state_q == S_WR);
  assign mem_addr_o  = ea_q;
  assign mem_wdata_o = result_q;
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;
  assign flags_out_o = flags_q;

  localparam logic [1:0] UNUSED_SET = KIND_SET;

endmodule

// File: tb/tb_z80_idx_bitop_rmw.sv
module tb_z80_idx_bitop_rmw;

  logic        clk;
  logic        reset;
  logic        opValid;
  logic        opReady;
  logic [1:0]  opKind;
  logic [2:0]  opBit;
  logic [2:0]  opShift;
  logic [15:0] base;
  logic [7:0]  disp;
  logic [7:0]  flagsIn;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic [7:0]  memRdata;
  logic        memAck;
  logic        done;
  logic [7:0]  result;
  logic [7:0]  flagsOut;

  int checks;
  int errors;

  // Observations from the most recent applyStimulus call
  logic [15:0] obsRdAddr;
  logic [15:0] obsWrAddr;
  logic [7:0]  obsWrData;
  logic [7:0]  obsResult;
  logic [7:0]  obsFlags;
  int          obsRdCount;
  int          obsWrCount;
  int          obsDoneCyc;
  int          obsDoneCount;
  bit          obsStable;
  bit          obsReadyBusy;

  z80_idx_bitop_rmw #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .WAIT_CYCLES(1)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .op_valid_i (opValid),
    .op_ready_o (opReady),
    .op_kind_i  (opKind),
    .op_bit_i   (opBit),
    .op_shift_i (opShift),
    .base_i     (base),
    .disp_i     (disp),
    .flags_in_i (flagsIn),
    .mem_req_o  (memReq),
    .mem_we_o   (memWe),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata),
    .mem_ack_i  (memAck),
    .done_o     (done),
    .result_o   (result),
    .flags_out_o(flagsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and act as the bus: ack a read after rdStall
  // stalled cycles and a write after wrStall. Cycle 1 is the first cycle
  // after the accepting edge. keepValid holds op_valid high (with a
  // different base) during the operation; spurAck drives ack while no
  // request is pending.
  task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] bitIdx,
                               input logic [2:0] shiftOp, input logic [15:0] baseAddr,
                               input logic [7:0] dispVal, input logic [7:0] fIn,
                               input logic [7:0] rdVal, input int rdStall, input int wrStall,
                               input bit keepValid, input bit spurAck);
    int rdWait;
    int wrWait;
    logic [15:0] phAddr;
    logic [7:0]  phData;
    rdWait = 0;
    wrWait = 0;
    phAddr = '0;
    phData = '0;
    obsRdAddr = '0; obsWrAddr = '0; obsWrData = '0; obsResult = '0; obsFlags = '0;
    obsRdCount = 0; obsWrCount = 0; obsDoneCyc = 0; obsDoneCount = 0;
    obsStable = 1'b1; obsReadyBusy = 1'b0;
    @(negedge clk);
    opValid = 1'b1; opKind = kind; opBit = bitIdx; opShift = shiftOp;
    base = baseAddr; disp = dispVal; flagsIn = fIn;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      memAck = 1'b0;
      if (keepValid) base = 16'h5555;
      else opValid = 1'b0;
      if (done) begin
        obsDoneCount++;
        if (obsDoneCyc == 0) begin
          obsDoneCyc = cyc; obsResult = result; obsFlags = flagsOut;
        end
        opValid = 1'b0;
      end else if (opReady && obsDoneCyc == 0) begin
        obsReadyBusy = 1'b1;
      end
      if (memReq && !memWe) begin
        if (rdWait == 0) phAddr = memAddr;
        else if (memAddr !== phAddr) obsStable = 1'b0;
        if (rdWait == rdStall) begin
          memAck = 1'b1; memRdata = rdVal; obsRdCount++; obsRdAddr = memAddr;
        end
        rdWait++;
      end else if (memReq && memWe) begin
        if (wrWait == 0) begin
          phAddr = memAddr; phData = memWdata;
        end else if (memAddr !== phAddr || memWdata !== phData) begin
          obsStable = 1'b0;
        end
        if (wrWait == wrStall) begin
          memAck = 1'b1; obsWrCount++; obsWrAddr = memAddr; obsWrData = memWdata;
        end
        wrWait++;
      end else if (spurAck && obsDoneCyc == 0) begin
        memAck = 1'b1;
      end
      if (obsDoneCyc != 0 && cyc >= obsDoneCyc + 2) break;
    end
    memAck = 1'b0;
    opValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (opReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", opReady); end
    checks++; if (memReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", memReq); end
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b expected 0", memWe); end
    checks++; if (memAddr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr got %h expected 0000", memAddr); end
    checks++; if (memWdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata got %h expected 00", memWdata); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("[TB] FAIL reset_result got %h expected 00", result); end
    checks++; if (flagsOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_flags got %h expected 00", flagsOut); end
    reset = 1'b0;
  endtask

  task automatic test_set();
    applyStimulus(2'b11, 3'd7, 3'd0, 16'h1000, 8'hFE, 8'hA5, 8'h01, 0, 0, 1'b0, 1'b0);
    checks++; if (obsRdAddr !== 16'h0FFE) begin errors++; $display("[TB] FAIL set_rdaddr got %h expected 0ffe", obsRdAddr); end
    checks++; if (obsWrAddr !== 16'h0FFE) begin errors++; $display("[TB] FAIL set_wraddr got %h expected 0ffe", obsWrAddr); end
    checks++; if (obsWrData !== 8'h81) begin errors++; $display("[TB] FAIL set_wdata got %h expected 81", obsWrData); end
    checks++; if (obsWrCount !== 1) begin errors++; $display("[TB] FAIL set_wrcount got %0d expected 1", obsWrCount); end
    checks++; if (obsDoneCyc !== 4) begin errors++; $display("[TB] FAIL set_latency got %0d expected 4", obsDoneCyc); end
    checks++; if (obsDoneCount !== 1) begin errors++; $display("[TB] FAIL set_donepulse got %0d expected 1", obsDoneCount); end
    checks++; if (obsResult !== 8'h81) begin errors++; $display("[TB] FAIL set_result got %h expected 81", obsResult); end
    checks++; if (obsFlags !== 8'hA5) begin errors++; $display("[TB] FAIL set_flags got %h expected a5", obsFlags); end
    checks++; if (obsReadyBusy !== 1'b0) begin errors++; $display("[TB] FAIL set_readybusy got %b expected 0", obsReadyBusy); end
  endtask

  task automatic test_wrap();
    applyStimulus(2'b10, 3'd0, 3'd0, 16'hFFFF, 8'h01, 8'h00, 8'hFF, 0, 0, 1'b0, 1'b0);
    checks++; if (obsRdAddr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_rdaddr got %h expected 0000", obsRdAddr); end
    checks++; if (obsWrAddr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_wraddr got %h expected 0000", obsWrAddr); end
    checks++; if (obsWrData !== 8'hFE) begin errors++; $display("[TB] FAIL wrap_wdata got %h expected fe", obsWrData); end
  endtask

  task automatic test_shift();
    // RLC 0x80 -> 0x01, carry out 1, odd parity
    applyStimulus(2'b00, 3'd0, 3'b000, 16'h4000, 8'h00, 8'h00, 8'h80, 0, 0, 1'b0, 1'b0);
    checks++; if (obsWrData !== 8'h01) begin errors++; $display("[TB] FAIL rlc_wdata got %h expected 01", obsWrData); end
    checks++; if (obsFlags !== 8'h01) begin errors++; $display("[TB] FAIL rlc_flags got %h expected 01", obsFlags); end
    // SRA 0x81 -> 0xC0, sign kept, even parity
    applyStimulus(2'b00, 3'd0, 3'b101, 16'h4000, 8'h01, 8'h00, 8'h81, 0, 0, 1'b0, 1'b0);
    checks++; if (obsWrData !== 8'hC0) begin errors++; $display("[TB] FAIL sra_wdata got %h expected c0", obsWrData); end
    checks++; if (obsFlags !== 8'h85) begin errors++; $display("[TB] FAIL sra_flags got %h expected 85", obsFlags); end
    // SRL 0x01 -> 0x00, zero result sets Z and P/V
    applyStimulus(2'b00, 3'd0, 3'b111, 16'h4000, 8'h02, 8'h00, 8'h01, 0, 0, 1'b0, 1'b0);
    checks++; if (obsWrData !== 8'h00) begin errors++; $display("[TB] FAIL srl_wdata got %h expected 00", obsWrData); end
    checks++; if (obsFlags !== 8'h45) begin errors++; $display("[TB] FAIL srl_flags got %h expected 45", obsFlags); end
    // RR 0x01 with C=1 -> 0x80, carry out 1
    applyStimulus(2'b00, 3'd0, 3'b011, 16'h4000, 8'h03, 8'h01, 8'h01, 0, 0, 1'b0, 1'b0);
    checks++; if (obsWrData !== 8'h80) begin errors++; $display("[TB] FAIL rr_wdata got %h expected 80", obsWrData); end
    checks++; if (obsFlags !== 8'h81) begin errors++; $display("[TB] FAIL rr_flags got %h expected 81", obsFlags); end
    // SLL 0x28 -> 0x51: shifts in a one, F5/F3 clear, odd parity
    applyStimulus(2'b00, 3'd0, 3'b110, 16'h4000, 8'h04, 8'h00, 8'h28, 0, 0, 1'b0, 1'b0);
    checks++; if (obsWrData !== 8'h51) begin errors++; $display("[TB] FAIL sll_wdata got %h expected 51", obsWrData); end
    checks++; if (obsFlags !== 8'h00) begin errors++; $display("[TB] FAIL sll_flags got %h expected 00", obsFlags); end
  endtask

  task automatic test_bit();
    applyStimulus(2'b01, 3'd3, 3'd0, 16'h2000, 8'h10, 8'h01, 8'hF7, 0, 0, 1'b0, 1'b0);
    checks++; if (obsRdAddr !== 16'h2010) begin errors++; $display("[TB] FAIL bit3_rdaddr got %h expected 2010", obsRdAddr); end
    checks++; if (obsRdCount !== 1) begin errors++; $display("[TB] FAIL bit3_rdcount got %0d expected 1", obsRdCount); end
    checks++; if (obsWrCount !== 0) begin errors++; $display("[TB] FAIL bit3_wrcount got %0d expected 0", obsWrCount); end
    checks++; if (obsDoneCyc !== 3) begin errors++; $display("[TB] FAIL bit3_latency got %0d expected 3", obsDoneCyc); end
    checks++; if (obsFlags !== 8'h75) begin errors++; $display("[TB] FAIL bit3_flags got %h expected 75", obsFlags); end
    checks++; if (obsResult !== 8'hF7) begin errors++; $display("[TB] FAIL bit3_result got %h expected f7", obsResult); end
    // BIT 7 of 0x80 at 0x2800: S set, Z clear, F5/F3 from EA high byte 0x28
    applyStimulus(2'b01, 3'd7, 3'd0, 16'h2800, 8'h00, 8'h00, 8'h80, 0, 0, 1'b0, 1'b0);
    checks++; if (obsFlags !== 8'hB8) begin errors++; $display("[TB] FAIL bit7_flags got %h expected b8", obsFlags); end
    checks++; if (obsWrCount !== 0) begin errors++; $display("[TB] FAIL bit7_wrcount got %0d expected 0", obsWrCount); end
  endtask

  task automatic test_stall();
    // SET 0 at 0x3000-128, read stalled 3 cycles, write stalled 2
    applyStimulus(2'b11, 3'd0, 3'd0, 16'h3000, 8'h80, 8'h00, 8'h10, 3, 2, 1'b1, 1'b1);
    checks++; if (obsDoneCyc !== 9) begin errors++; $display("[TB] FAIL stall_latency got %0d expected 9", obsDoneCyc); end
    checks++; if (obsStable !== 1'b1) begin errors++; $display("[TB] FAIL stall_stable got %b expected 1", obsStable); end
    checks++; if (obsRdAddr !== 16'h2F80) begin errors++; $display("[TB] FAIL stall_rdaddr got %h expected 2f80", obsRdAddr); end
    checks++; if (obsWrAddr !== 16'h2F80) begin errors++; $display("[TB] FAIL stall_wraddr got %h expected 2f80", obsWrAddr); end
    checks++; if (obsWrData !== 8'h11) begin errors++; $display("[TB] FAIL stall_wdata got %h expected 11", obsWrData); end
    checks++; if (obsRdCount !== 1) begin errors++; $display("[TB] FAIL stall_rdcount got %0d expected 1", obsRdCount); end
    checks++; if (obsDoneCount !== 1) begin errors++; $display("[TB] FAIL stall_donepulse got %0d expected 1", obsDoneCount); end
  endtask

  task automatic test_reset_mid();
    int reqSeen;
    reqSeen = 0;
    @(negedge clk);
    opValid = 1'b1; opKind = 2'b11; opBit = 3'd7; opShift = 3'd0;
    base = 16'h1000; disp = 8'h00; flagsIn = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    opValid = 1'b0;
    checks++; if (memReq !== 1'b1) begin errors++; $display("[TB] FAIL rmid_rdreq got %b expected 1", memReq); end
    memAck = 1'b1; memRdata = 8'h01;
    @(negedge clk);
    memAck = 1'b0;
    checks++; if (memReq !== 1'b0) begin errors++; $display("[TB] FAIL rmid_waitreq got %b expected 0", memReq); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (opReady !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready got %b expected 1", opReady); end
    checks++; if (memAddr !== 16'h0000) begin errors++; $display("[TB] FAIL rmid_addr got %h expected 0000", memAddr); end
    checks++; if (memWdata !== 8'h00) begin errors++; $display("[TB] FAIL rmid_wdata got %h expected 00", memWdata); end
    checks++; if (result !== 8'h00) begin errors++; $display("[TB] FAIL rmid_result got %h expected 00", result); end
    checks++; if (flagsOut !== 8'h00) begin errors++; $display("[TB] FAIL rmid_flags got %h expected 00", flagsOut); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done got %b expected 0", done); end
    for (int i = 0; i < 6; i++) begin
      if (memReq) reqSeen++;
      @(negedge clk);
    end
    checks++; if (reqSeen !== 0) begin errors++; $display("[TB] FAIL rmid_noreq got %0d expected 0", reqSeen); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(2'b10, 3'd7, 3'd0, 16'h0100, 8'h7F, 8'h3C, 8'hFF, 0, 0, 1'b0, 1'b0);
    checks++; if (obsWrAddr !== 16'h017F) begin errors++; $display("[TB] FAIL b2b1_wraddr got %h expected 017f", obsWrAddr); end
    checks++; if (obsWrData !== 8'h7F) begin errors++; $display("[TB] FAIL b2b1_wdata got %h expected 7f", obsWrData); end
    checks++; if (obsFlags !== 8'h3C) begin errors++; $display("[TB] FAIL b2b1_flags got %h expected 3c", obsFlags); end
    applyStimulus(2'b00, 3'd0, 3'b010, 16'h0200, 8'h00, 8'h01, 8'h00, 1, 0, 1'b0, 1'b0);
    checks++; if (obsWrData !== 8'h01) begin errors++; $display("[TB] FAIL b2b2_wdata got %h expected 01", obsWrData); end
    checks++; if (obsFlags !== 8'h00) begin errors++; $display("[TB] FAIL b2b2_flags got %h expected 00", obsFlags); end
    checks++; if (obsDoneCyc !== 5) begin errors++; $display("[TB] FAIL b2b2_latency got %0d expected 5", obsDoneCyc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    opValid = 1'b0; opKind = 2'b00; opBit = 3'd0; opShift = 3'd0;
    base = 16'h0000; disp = 8'h00; flagsIn = 8'h00;
    memRdata = 8'h00; memAck = 1'b0;
    test_reset();
    test_set();
    test_wrap();
    test_shift();
    test_bit();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80_idx_bitop_rmw.md
Name: z80_idx_bitop_rmw

Overview:
Sequential read-modify-write engine for the DDCB/FDCB indexed bit-op family: SET, RES, BIT and the eight rotate/shift ops on (base + d). It generalises the fixed SET/RES-indexed behaviour with:
- parametrised address and data widths;
- a configurable internal-delay phase;
- a bus request/acknowledge handshake;
- Z80 flag generation.

It sits between the core's CB-prefix decoder and the memory bus arbiter, and owns the whole memory phase of the instruction.

Parameters:
ADDR_WIDTH, 16, width of base, effective address and mem_addr
DATA_WIDTH, 8, operand width; legal values 8 or 16; BW = $clog2(DATA_WIDTH)
WAIT_CYCLES, 1, internal cycles between read data capture and write/complete (0 = none)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
op_valid  input  1  operation request
op_ready  output  1  engine can accept an operation
op_kind  input  2  00 rotate/shift, 01 BIT, 10 RES, 11 SET
op_bit  input  BW  bit index for BIT/RES/SET
op_shift  input  3  000 RLC, 001 RRC, 010 RL, 011 RR, 100 SLA, 101 SRA, 110 SLL, 111 SRL
base  input  ADDR_WIDTH  IX or IY value
disp  input  8  signed displacement d
flags_in  input  8  current F register (C used by RL/RR; all bits preserved where required)
mem_req  output  1  bus cycle request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_WIDTH  effective address
mem_wdata  output  DATA_WIDTH  write data
mem_rdata  input  DATA_WIDTH  read data, valid when mem_ack=1 during a read
mem_ack  input  1  bus cycle complete
done  output  1  one-cycle completion pulse
result  output  DATA_WIDTH  modified value (BIT: the read value)
flags_out  output  8  new F value; valid while done=1

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; op_ready=1; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; done=0; result=0; flags_out=0.
- Reset mid-operation: at the next edge go to IDLE and drop mem_req. No write is issued after reset is sampled.
- States: IDLE → RD → WAIT → WR → DONE → IDLE.
- IDLE:
  - op_ready=1.
  - On op_valid, latch all op inputs.
  - Latch EA = base + sign-extend(disp), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
  - Go to RD.
- RD:
  - mem_req=1, mem_we=0, mem_addr=EA.
  - Hold until mem_ack=1 is sampled; capture mem_rdata on that edge.
  - Then go to WAIT if WAIT_CYCLES>0, else to WR (or to DONE for BIT).
- WAIT:
  - Count WAIT_CYCLES cycles with mem_req=0.
  - Then go to WR, or to DONE if op_kind=BIT.
- WR:
  - mem_req=1, mem_we=1, mem_addr=EA, mem_wdata=result.
  - Hold stable until mem_ack is sampled; then go to DONE.
- DONE: done=1 for exactly one cycle, result/flags_out valid; then IDLE.
- op_ready is 1 only in IDLE. op_valid outside IDLE is ignored.
- mem_ack while mem_req=0 is ignored. An ack in the first cycle of a request is legal, so each bus phase takes a minimum of 1 cycle.
- Latency, acks immediate, WAIT_CYCLES=1, accept at cycle 0:
  - non-BIT: RD c1, WAIT c2, WR c3, done c4;
  - BIT: done c3.
- Result arithmetic, with msb = bit DATA_WIDTH-1:
  - SET: r = d | (1<<b).
  - RES: r = d & ~(1<<b).
  - Rotates/shifts are standard Z80 over the full DATA_WIDTH. SLL shifts in 1; SRA keeps msb. C = the bit shifted out.
- Flags, SET/RES: flags_out = flags_in.
- Flags, rotate/shift:
  - S = r[msb]; Z = (r==0).
  - F5 = r[5], F3 = r[3]; H=0; N=0.
  - P/V = even parity over all DATA_WIDTH bits.
  - C = carry out.
- Flags, BIT:
  - Z = ~d[b]; P/V = Z; H=1; N=0.
  - S = (b==msb) & d[b].
  - F5/F3 = EA[13]/EA[11], i.e. bits 5/3 of EA high byte (ADDR_WIDTH=16).
  - C = flags_in[0].
  - No write cycle is issued.

Test Plan:
- SET 7 (op_kind 11, op_bit 7), base 0x1000, disp 0xFE, rdata 0x01 → read at 0x0FFE, write 0x81 to 0x0FFE, done at c4, flags_out=flags_in.
- Wrap: RES 0, base 0xFFFF, disp 0x01, rdata 0xFF → addr 0x0000 for both cycles, write 0xFE.
- RLC, rdata 0x80 → write 0x01, flags_out 0x01. SRA, rdata 0x81 → write 0xC0, flags_out 0x85.
- BIT 3, base 0x2000, disp 0x10, rdata 0xF7, flags_in 0x01 → read 0x2010 only, no write, done at c3, flags_out 0x75.
- Bus stall: mem_ack held low 3 cycles in RD and 2 in WR → mem_req/we/addr/wdata stable throughout, done 5 cycles later than the no-stall case. A second op_valid during the operation is ignored.
- Reset asserted during WAIT → mem_req stays 0, no write occurs, op_ready=1 next cycle, all outputs at reset values.
